// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage between the program counter and decode.
// Optional fetch timeout / sticky fault enabled with `define IFETCH_TIMEOUT_EN.
module instruction_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic        pc_enable,
  output logic        pc_inc_or_set,
  output logic [15:0] pc_new_address,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic [15:0] instr_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  output logic        fetch_fault
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  // Reject out-of-range timeout limits at elaboration.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("instruction_fetch: TIMEOUT_CYCLES must be within 1..65535");
  end

`ifdef IFETCH_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_HOLD, S_ADVANCE, S_DRAIN, S_FAULT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_HOLD, S_ADVANCE, S_DRAIN
  } state_t;
`endif

  state_t        state, state_next;
  logic [DW-1:0] instr_next;
  logic [AW-1:0] instr_addr_next;
  logic          pend_set, pend_set_next;
  logic [AW-1:0] pend_target, pend_target_next;

`ifdef IFETCH_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt, wait_cnt_next;
`endif

  // Next-state and datapath register updates.
  always_comb begin
    state_next       = state;
    instr_next       = instr;
    instr_addr_next  = instr_addr;
    pend_set_next    = pend_set;
    pend_target_next = pend_target;

    case (state)
      S_IDLE:    state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          instr_next      = mem_rdata;
          instr_addr_next = pc;
          state_next      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pend_set_next = 1'b0;
          state_next    = S_ADVANCE;
        end
      end
      S_ADVANCE: state_next = S_FETCH;
      S_DRAIN: begin
        if (mem_ack) state_next = S_ADVANCE;
      end
      default:   state_next = S_IDLE;
    endcase

    // Redirect outranks every other event; in-flight data is discarded.
    if (redirect) begin
      pend_set_next    = 1'b1;
      pend_target_next = redirect_target;
      instr_next       = instr;
      instr_addr_next  = instr_addr;
      case (state)
        S_IDLE, S_HOLD, S_ADVANCE: state_next = S_ADVANCE;
        S_FETCH:                   state_next = mem_ack ? S_ADVANCE : S_DRAIN;
        default:                   ;
      endcase
    end

`ifdef IFETCH_TIMEOUT_EN
    wait_cnt_next = wait_cnt;
    if (state == S_FAULT) begin
      // Only reset leaves the fault state; redirects are ignored here.
      state_next       = S_FAULT;
      pend_set_next    = pend_set;
      pend_target_next = pend_target;
    end else if ((state == S_FETCH || state == S_DRAIN) && !mem_ack && !redirect &&
                 wait_cnt == TIMEOUT_LAST) begin
      state_next = S_FAULT;
    end
    if ((state_next == S_FETCH || state_next == S_DRAIN) && state_next != state) begin
      wait_cnt_next = 16'd0;
    end else if ((state == S_FETCH || state == S_DRAIN) && !mem_ack) begin
      wait_cnt_next = wait_cnt + 16'd1;
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      instr       <= '0;
      instr_addr  <= '0;
      pend_set    <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_next;
      instr       <= instr_next;
      instr_addr  <= instr_addr_next;
      pend_set    <= pend_set_next;
      pend_target <= pend_target_next;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  // Wait counter for the outstanding memory request.
  always_ff @(posedge clock) begin
    if (reset) wait_cnt <= 16'd0;
    else       wait_cnt <= wait_cnt_next;
  end

  assign fetch_fault = (state == S_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

  // Control outputs decoded from the registered state only.
  always_comb begin
    mem_req        = 1'b0;
    instr_valid    = 1'b0;
    pc_enable      = 1'b0;
    pc_inc_or_set  = 1'b0;
    pc_new_address = '0;
    case (state)
      S_FETCH, S_DRAIN: mem_req = 1'b1;
      S_HOLD:           instr_valid = 1'b1;
      S_ADVANCE: begin
        pc_enable      = 1'b1;
        pc_inc_or_set  = pend_set;
        pc_new_address = pend_target;
      end
      default: ;
    endcase
  end

  // Fetch address follows the PC while a request is outstanding.
  assign mem_addr = mem_req ? pc : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; with IFETCH_TIMEOUT_EN defined it also
// exercises the timeout fault (TIMEOUT_CYCLES = 8).
module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic [15:0] pc;
  logic        pc_enable;
  logic        pc_inc_or_set;
  logic [15:0] pc_new_address;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        fetch_fault;

  logic        pc_force;
  logic [15:0] pc_force_val;
  int          checks;
  int          errors;
  int          pe_count;
  int          pe_before;

  instruction_fetch #(.TIMEOUT_CYCLES(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc              (pc),
    .pc_enable       (pc_enable),
    .pc_inc_or_set   (pc_inc_or_set),
    .pc_new_address  (pc_new_address),
    .mem_addr        (mem_addr),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .instr           (instr),
    .instr_addr      (instr_addr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_fault     (fetch_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Program counter model driven by the fetch stage's PC controls.
  always @(posedge clock) begin
    if (pc_force)       pc <= pc_force_val;
    else if (pc_enable) pc <= pc_inc_or_set ? pc_new_address : pc + 16'd1;
  end

  // Count PC update pulses.
  always @(posedge clock) begin
    if (pc_enable === 1'b1) pe_count <= pe_count + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    checks = 0; errors = 0; pe_count = 0; pe_before = 0;
    pc = 16'h0000;
    reset = 1'b1; pc_force = 1'b1; pc_force_val = 16'h0010;
    mem_ack = 1'b0; mem_rdata = 16'h0000; instr_ready = 1'b0;
    redirect = 1'b0; redirect_target = 16'h0000;
    @(negedge clock);
    tick(); tick();

    // Reset values
    check("rst_mem_req", 16'(mem_req), 16'h0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_valid", 16'(instr_valid), 16'h0);
    check("rst_pc_enable", 16'(pc_enable), 16'h0);
    check("rst_instr", instr, 16'h0);
    check("rst_instr_addr", instr_addr, 16'h0);
    check("rst_fault", 16'(fetch_fault), 16'h0);

    // Basic fetch with zero-wait memory and ready decode
    reset = 1'b0; pc_force = 1'b0;
    tick();
    check("t1_req", 16'(mem_req), 16'h1);
    check("t1_addr", mem_addr, 16'h0010);
    mem_ack = 1'b1; mem_rdata = 16'h1234; instr_ready = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t1_valid", 16'(instr_valid), 16'h1);
    check("t1_instr", instr, 16'h1234);
    check("t1_instr_addr", instr_addr, 16'h0010);
    check("t1_no_pe_hold", 16'(pc_enable), 16'h0);
    tick();
    check("t1_pe", 16'(pc_enable), 16'h1);
    check("t1_inc", 16'(pc_inc_or_set), 16'h0);
    check("t1_valid_drop", 16'(instr_valid), 16'h0);
    tick();
    check("t1_next_addr", mem_addr, 16'h0011);
    check("t1_next_req", 16'(mem_req), 16'h1);
    check("t1_pe_low", 16'(pc_enable), 16'h0);

    // Slow memory and stalled decode
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_req_stable", 16'(mem_req), 16'h1);
      check("t2_addr_stable", mem_addr, 16'h0011);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    pe_before = pe_count;
    for (int i = 0; i < 3; i++) begin
      check("t2_valid", 16'(instr_valid), 16'h1);
      check("t2_instr", instr, 16'hBEEF);
      check("t2_instr_addr", instr_addr, 16'h0011);
      check("t2_no_pe", 16'(pc_enable), 16'h0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    check("t2_pe", 16'(pc_enable), 16'h1);
    check("t2_inc", 16'(pc_inc_or_set), 16'h0);
    tick();
    check("t2_next_addr", mem_addr, 16'h0012);
    check("t2_one_pe", 16'(pe_count - pe_before), 16'h1);

    // Redirect in HOLD squashes the instruction even with ready high
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    check("t3_valid", 16'(instr_valid), 16'h1);
    check("t3_instr", instr, 16'h5555);
    redirect = 1'b1; redirect_target = 16'h0200;
    tick();
    redirect = 1'b0;
    check("t3_valid_drop", 16'(instr_valid), 16'h0);
    check("t3_pe", 16'(pc_enable), 16'h1);
    check("t3_set", 16'(pc_inc_or_set), 16'h1);
    check("t3_target", pc_new_address, 16'h0200);
    tick();
    check("t3_fetch_target", mem_addr, 16'h0200);
    check("t3_pe_low", 16'(pc_enable), 16'h0);

    // Redirect during an outstanding fetch, ack two cycles later
    redirect = 1'b1; redirect_target = 16'h0300;
    tick();
    redirect = 1'b0;
    check("t4_drain_req", 16'(mem_req), 16'h1);
    check("t4_drain_addr", mem_addr, 16'h0200);
    check("t4_drain_valid", 16'(instr_valid), 16'h0);
    tick();
    check("t4_drain_req2", 16'(mem_req), 16'h1);
    check("t4_drain_no_pe", 16'(pc_enable), 16'h0);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    check("t4_valid", 16'(instr_valid), 16'h0);
    check("t4_pe", 16'(pc_enable), 16'h1);
    check("t4_set", 16'(pc_inc_or_set), 16'h1);
    check("t4_target", pc_new_address, 16'h0300);
    check("t4_discard", instr, 16'h5555);
    tick();
    check("t4_fetch_target", mem_addr, 16'h0300);

    // Normal accept clears the pending set
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    check("t5_instr", instr, 16'h1111);
    check("t5_instr_addr", instr_addr, 16'h0300);
    tick();
    check("t5_inc_after_set", 16'(pc_inc_or_set), 16'h0);
    tick();
    check("t5_addr_301", mem_addr, 16'h0301);

    // Redirect with ack in the same FETCH cycle discards the data
    redirect = 1'b1; redirect_target = 16'hFFFF;
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    redirect = 1'b0; mem_ack = 1'b0;
    check("t5_pe", 16'(pc_enable), 16'h1);
    check("t5_set", 16'(pc_inc_or_set), 16'h1);
    check("t5_target", pc_new_address, 16'hFFFF);
    check("t5_valid", 16'(instr_valid), 16'h0);
    check("t5_discard", instr, 16'h1111);
    tick();
    check("t5_addr_ffff", mem_addr, 16'hFFFF);

    // Fetch at 0xFFFF wraps to 0x0000
    mem_ack = 1'b1; mem_rdata = 16'hABCD;
    tick();
    mem_ack = 1'b0;
    check("t6_instr", instr, 16'hABCD);
    check("t6_instr_addr", instr_addr, 16'hFFFF);
    tick();
    check("t6_pe", 16'(pc_enable), 16'h1);
    check("t6_inc", 16'(pc_inc_or_set), 16'h0);
    tick();
    check("t6_wrap_addr", mem_addr, 16'h0000);

    // Redirect during ADVANCE issues a second, set pulse
    mem_ack = 1'b1; mem_rdata = 16'h0F0F;
    tick();
    mem_ack = 1'b0;
    tick();
    check("t7_pe1", 16'(pc_enable), 16'h1);
    check("t7_inc1", 16'(pc_inc_or_set), 16'h0);
    redirect = 1'b1; redirect_target = 16'h0400;
    tick();
    redirect = 1'b0;
    check("t7_pe2", 16'(pc_enable), 16'h1);
    check("t7_set2", 16'(pc_inc_or_set), 16'h1);
    check("t7_target2", pc_new_address, 16'h0400);
    tick();
    check("t7_addr_400", mem_addr, 16'h0400);
    check("t7_pe_low", 16'(pc_enable), 16'h0);

    // Reset mid-fetch abandons the request
    reset = 1'b1; pc_force = 1'b1; pc_force_val = 16'h0050;
    tick();
    check("t8_req", 16'(mem_req), 16'h0);
    check("t8_addr", mem_addr, 16'h0);
    check("t8_pe", 16'(pc_enable), 16'h0);
    check("t8_instr", instr, 16'h0);
    check("t8_valid", 16'(instr_valid), 16'h0);
    reset = 1'b0; pc_force = 1'b0;
    tick();

`ifdef IFETCH_TIMEOUT_EN
    // Timeout after 8 FETCH cycles without ack
    for (int i = 0; i < 8; i++) begin
      check("t9_req", 16'(mem_req), 16'h1);
      check("t9_no_fault", 16'(fetch_fault), 16'h0);
      tick();
    end
    check("t9_fault", 16'(fetch_fault), 16'h1);
    check("t9_fault_req", 16'(mem_req), 16'h0);
    check("t9_fault_valid", 16'(instr_valid), 16'h0);
    redirect = 1'b1; redirect_target = 16'h0600; mem_ack = 1'b1;
    tick();
    redirect = 1'b0; mem_ack = 1'b0;
    check("t9_sticky", 16'(fetch_fault), 16'h1);
    check("t9_no_pe", 16'(pc_enable), 16'h0);
    tick();
    check("t9_sticky2", 16'(fetch_fault), 16'h1);
    check("t9_no_pe2", 16'(pc_enable), 16'h0);
    reset = 1'b1;
    tick();
    check("t9_clear", 16'(fetch_fault), 16'h0);
    reset = 1'b0;
    tick();
`else
    // Without timeout the wait is unbounded and no fault appears
    for (int i = 0; i < 20; i++) tick();
    check("t9_req_held", 16'(mem_req), 16'h1);
    check("t9_no_fault", 16'(fetch_fault), 16'h0);
`endif
    check("t9_addr", mem_addr, 16'h0050);
    mem_ack = 1'b1; mem_rdata = 16'h4242;
    tick();
    mem_ack = 1'b0;
    check("t9_instr", instr, 16'h4242);
    check("t9_instr_addr", instr_addr, 16'h0050);
    check("t9_valid", 16'(instr_valid), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
